mem_arb: RTL and testbench

- Two-to-one memory port arbiter. Lets the instruction-fetch requester (IFU) and the load/store requester (LSU) share one downstream memory port.
- Sits between the core's io_ifu_*/io_lsu_* interfaces and the memory/bus adapter.
- Allows one outstanding transaction at a time.
- Latches the granted request, routes the response back to the owner only, and completes a stalled transaction with an error after a watchdog timeout.

---
 rtl/mem_arb.sv | 126 ++++++++++++
 tb/tb_mem_arb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Two-to-one memory port arbiter: IFU and LSU share a single downstream port with one
// outstanding transaction, owner-only response routing and a watchdog timeout completion.
module mem_arb #(
  parameter bit          LSU_PRIORITY   = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_ifu_reqValid,
  input  logic [31:0] io_ifu_addr,
  output logic        io_ifu_respValid,
  output logic [31:0] io_ifu_rdata,
  input  logic        io_lsu_reqValid,
  input  logic [31:0] io_lsu_addr,
  input  logic [1:0]  io_lsu_size,
  input  logic        io_lsu_wen,
  input  logic [31:0] io_lsu_wdata,
  input  logic [3:0]  io_lsu_wmask,
  output logic        io_lsu_respValid,
  output logic [31:0] io_lsu_rdata,
  output logic        io_mem_reqValid,
  output logic [31:0] io_mem_addr,
  output logic [1:0]  io_mem_size,
  output logic        io_mem_wen,
  output logic [31:0] io_mem_wdata,
  output logic [3:0]  io_mem_wmask,
  input  logic        io_mem_respValid,
  input  logic [31:0] io_mem_rdata,
  output logic        timeout_err
);

  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, GNT_IFU, GNT_LSU} state_t;

  state_t        state_q;
  logic          last_lsu_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [31:0]   addr_q;
  logic [1:0]    size_q;
  logic          wen_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wmask_q;

  logic        granted;
  logic        wd_fire;
  logic        done;
  logic        lsu_wins;
  logic [31:0] resp_data;

  assign granted   = (state_q != IDLE);
  assign wd_fire   = (TIMEOUT_CYCLES != 0) && granted && !io_mem_respValid && (cnt_q == CNT_LIMIT);
  assign done      = granted && (io_mem_respValid || wd_fire);
  assign resp_data = io_mem_respValid ? io_mem_rdata : TIMEOUT_RDATA;

  // On a tie the LSU wins under fixed priority, or when the IFU was served last.
  assign lsu_wins = io_lsu_reqValid && (!io_ifu_reqValid || LSU_PRIORITY || !last_lsu_q);

  always_comb begin
    cnt_d = cnt_q;
    if (done || !granted) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_lsu_q <= 1'b1;
      cnt_q      <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (lsu_wins) begin
            state_q <= GNT_LSU;
            addr_q  <= io_lsu_addr;
            size_q  <= io_lsu_size;
            wen_q   <= io_lsu_wen;
            wdata_q <= io_lsu_wdata;
            wmask_q <= io_lsu_wmask;
          end else if (io_ifu_reqValid) begin
            state_q <= GNT_IFU;
            addr_q  <= io_ifu_addr;
            size_q  <= 2'b10;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= 4'b0000;
          end
        end
        GNT_IFU, GNT_LSU: begin
          if (done) begin
            state_q    <= IDLE;
            last_lsu_q <= (state_q == GNT_LSU);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_mem_reqValid  = granted && !wd_fire;
  assign io_mem_addr      = addr_q;
  assign io_mem_size      = size_q;
  assign io_mem_wen       = wen_q;
  assign io_mem_wdata     = wdata_q;
  assign io_mem_wmask     = wmask_q;
  assign timeout_err      = wd_fire;

  assign io_ifu_respValid = done && (state_q == GNT_IFU);
  assign io_lsu_respValid = done && (state_q == GNT_LSU);
  assign io_ifu_rdata     = io_ifu_respValid ? resp_data : 32'h0;
  assign io_lsu_rdata     = io_lsu_respValid ? resp_data : 32'h0;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: instance a uses LSU priority, instance b round-robin;
// both use a 4-cycle watchdog and share every input.
module tb_mem_arb;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ifu_req = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        lsu_req = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [1:0]  lsu_size = '0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        mem_resp = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        a_ifu_resp, a_lsu_resp, a_mem_req, a_mem_wen, a_terr;
  logic [31:0] a_ifu_rdata, a_lsu_rdata, a_mem_addr, a_mem_wdata;
  logic [1:0]  a_mem_size;
  logic [3:0]  a_mem_wmask;
  logic        b_ifu_resp, b_lsu_resp, b_mem_req, b_mem_wen, b_terr;
  logic [31:0] b_ifu_rdata, b_lsu_rdata, b_mem_addr, b_mem_wdata;
  logic [1:0]  b_mem_size;
  logic [3:0]  b_mem_wmask;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  mem_arb #(.LSU_PRIORITY(1'b1), .TIMEOUT_CYCLES(4)) dut_a (
    .clock(clock), .reset(reset),
    .io_ifu_reqValid(ifu_req), .io_ifu_addr(ifu_addr),
    .io_ifu_respValid(a_ifu_resp), .io_ifu_rdata(a_ifu_rdata),
    .io_lsu_reqValid(lsu_req), .io_lsu_addr(lsu_addr), .io_lsu_size(lsu_size),
    .io_lsu_wen(lsu_wen), .io_lsu_wdata(lsu_wdata), .io_lsu_wmask(lsu_wmask),
    .io_lsu_respValid(a_lsu_resp), .io_lsu_rdata(a_lsu_rdata),
    .io_mem_reqValid(a_mem_req), .io_mem_addr(a_mem_addr), .io_mem_size(a_mem_size),
    .io_mem_wen(a_mem_wen), .io_mem_wdata(a_mem_wdata), .io_mem_wmask(a_mem_wmask),
    .io_mem_respValid(mem_resp), .io_mem_rdata(mem_rdata), .timeout_err(a_terr)
  );

  mem_arb #(.LSU_PRIORITY(1'b0), .TIMEOUT_CYCLES(4)) dut_b (
    .clock(clock), .reset(reset),
    .io_ifu_reqValid(ifu_req), .io_ifu_addr(ifu_addr),
    .io_ifu_respValid(b_ifu_resp), .io_ifu_rdata(b_ifu_rdata),
    .io_lsu_reqValid(lsu_req), .io_lsu_addr(lsu_addr), .io_lsu_size(lsu_size),
    .io_lsu_wen(lsu_wen), .io_lsu_wdata(lsu_wdata), .io_lsu_wmask(lsu_wmask),
    .io_lsu_respValid(b_lsu_resp), .io_lsu_rdata(b_lsu_rdata),
    .io_mem_reqValid(b_mem_req), .io_mem_addr(b_mem_addr), .io_mem_size(b_mem_size),
    .io_mem_wen(b_mem_wen), .io_mem_wdata(b_mem_wdata), .io_mem_wmask(b_mem_wmask),
    .io_mem_respValid(mem_resp), .io_mem_rdata(mem_rdata), .timeout_err(b_terr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_inputs();
    ifu_req = 0; ifu_addr = '0; lsu_req = 0; lsu_addr = '0; lsu_size = '0;
    lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0; mem_resp = 0; mem_rdata = '0;
  endtask

  // Leaves the bench in "cycle 0": reset just released, next edge is the first active one.
  task automatic reset_dut();
    clear_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    clear_inputs();
    #1;
    chk("rst_mem_req", {31'd0, a_mem_req}, 32'd0);
    reset_dut();
    #1;
    chk("post_rst_mem_req", {31'd0, a_mem_req}, 32'd0);
    chk("post_rst_addr", a_mem_addr, 32'd0);
    chk("post_rst_resp", {30'd0, a_ifu_resp, a_lsu_resp}, 32'd0);

    // Single IFU fetch
    cyc(); ifu_req = 1; ifu_addr = 32'h8000_0000; #1;
    chk("fetch_c1_mem_req", {31'd0, a_mem_req}, 32'd0);
    cyc(); #1;
    chk("fetch_c2_mem_req", {31'd0, a_mem_req}, 32'd1);
    chk("fetch_c2_addr", a_mem_addr, 32'h8000_0000);
    chk("fetch_c2_fields", {25'd0, a_mem_size, a_mem_wen, a_mem_wmask}, {25'd0, 2'b10, 1'b0, 4'h0});
    cyc(); #1;
    chk("fetch_c3_mem_req", {31'd0, a_mem_req}, 32'd1);
    cyc(); mem_resp = 1; mem_rdata = 32'h0000_0013; #1;
    chk("fetch_c4_ifu_resp", {31'd0, a_ifu_resp}, 32'd1);
    chk("fetch_c4_ifu_rdata", a_ifu_rdata, 32'h13);
    chk("fetch_c4_lsu_resp", {31'd0, a_lsu_resp}, 32'd0);
    chk("fetch_c4_lsu_rdata", a_lsu_rdata, 32'd0);
    cyc(); ifu_req = 0; mem_resp = 0; #1;
    chk("fetch_c5_mem_req", {31'd0, a_mem_req}, 32'd0);
    $display("txn: ifu fetch 0x80000000 complete");

    // Simultaneous requests, LSU priority
    reset_dut();
    cyc(); ifu_req = 1; ifu_addr = 32'h100;
    lsu_req = 1; lsu_addr = 32'h200; lsu_size = 2; lsu_wen = 1; lsu_wdata = 32'hA5A5_A5A5; lsu_wmask = 4'hF;
    cyc(); #1;
    chk("prio_lsu_addr", a_mem_addr, 32'h200);
    chk("prio_lsu_wdata", a_mem_wdata, 32'hA5A5_A5A5);
    chk("prio_lsu_wen_mask", {27'd0, a_mem_wen, a_mem_wmask}, {27'd0, 1'b1, 4'hF});
    cyc(); mem_resp = 1; mem_rdata = 32'h0; #1;
    chk("prio_lsu_resp", {30'd0, a_ifu_resp, a_lsu_resp}, 32'd1);
    cyc(); lsu_req = 0; mem_resp = 0; #1;
    chk("prio_gap_mem_req", {31'd0, a_mem_req}, 32'd0);
    cyc(); #1;
    chk("prio_ifu_mem_req", {31'd0, a_mem_req}, 32'd1);
    chk("prio_ifu_addr", a_mem_addr, 32'h100);
    chk("prio_ifu_fields", {a_mem_wdata[27:0], a_mem_wen, a_mem_wmask[2:0]}, 32'd0);
    cyc(); mem_resp = 1; mem_rdata = 32'h0BAD_F00D; #1;
    chk("prio_ifu_rdata", a_ifu_rdata, 32'h0BAD_F00D);
    cyc(); ifu_req = 0; mem_resp = 0;
    $display("txn: lsu store 0x200 then ifu fetch 0x100 complete");

    // Round-robin on instance b
    reset_dut();
    cyc(); ifu_req = 1; ifu_addr = 32'h100; lsu_req = 1; lsu_addr = 32'h200; lsu_size = 2; lsu_wen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_idle_mem_req", {31'd0, b_mem_req}, 32'd0);
      cyc(); mem_resp = 1; mem_rdata = 32'(i + 1); #1;
      chk("rr_addr", b_mem_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      chk("rr_owner", {30'd0, b_ifu_resp, b_lsu_resp}, (i % 2 == 0) ? 32'd2 : 32'd1);
      $display("txn: rr grant %0d to %s", i, (b_ifu_resp ? "ifu" : "lsu"));
      cyc(); mem_resp = 0;
    end
    clear_inputs();

    // Watchdog timeout, then a late response
    reset_dut();
    cyc(); lsu_req = 1; lsu_addr = 32'h300; lsu_size = 2;
    cyc(); #1;
    chk("to_mem_req", {31'd0, a_mem_req}, 32'd1);
    for (int k = 1; k < 4; k++) begin
      cyc(); #1;
      chk("to_early", {30'd0, a_terr, a_lsu_resp}, 32'd0);
    end
    cyc(); #1;
    chk("to_fire_resp", {30'd0, a_terr, a_lsu_resp}, 32'd3);
    chk("to_fire_rdata", a_lsu_rdata, 32'hDEAD_BEEF);
    cyc(); lsu_req = 0; #1;
    chk("to_after_mem_req", {31'd0, a_mem_req}, 32'd0);
    cyc(); mem_resp = 1; mem_rdata = 32'h77; #1;
    chk("to_late_resp", {30'd0, a_ifu_resp, a_lsu_resp}, 32'd0);
    chk("to_late_rdata", a_lsu_rdata, 32'd0);
    cyc(); mem_resp = 0;
    $display("txn: lsu load 0x300 timed out");

    // Response in the limit cycle beats the watchdog
    reset_dut();
    cyc(); lsu_req = 1; lsu_addr = 32'h304; lsu_size = 2;
    cyc(); cyc(); cyc(); cyc();
    cyc(); mem_resp = 1; mem_rdata = 32'h1234; #1;
    chk("tie_resp", {30'd0, a_terr, a_lsu_resp}, 32'd1);
    chk("tie_rdata", a_lsu_rdata, 32'h1234);
    cyc(); lsu_req = 0; mem_resp = 0;
    $display("txn: lsu load 0x304 completed at limit");

    // Reset mid-transaction
    reset_dut();
    cyc(); lsu_req = 1; lsu_addr = 32'h400; lsu_size = 0; lsu_wen = 1; lsu_wdata = 32'h55; lsu_wmask = 4'h3;
    cyc(); #1;
    chk("mid_mem_wmask", {27'd0, a_mem_req, a_mem_wmask}, {27'd0, 1'b1, 4'h3});
    #2; reset = 1; lsu_req = 0; #1;
    chk("mid_rst_outputs", {a_mem_addr[29:0], a_mem_req, a_mem_wen}, 32'd0);
    chk("mid_rst_wdata", a_mem_wdata, 32'd0);
    cyc(); reset = 0; mem_resp = 1; mem_rdata = 32'h99; #1;
    chk("mid_stale_resp", {30'd0, a_ifu_resp, a_lsu_resp}, 32'd0);
    cyc(); mem_resp = 0; ifu_req = 1; ifu_addr = 32'h500; #1;
    chk("mid_new_idle", {31'd0, a_mem_req}, 32'd0);
    cyc(); #1;
    chk("mid_new_grant", {a_mem_addr[30:0], a_mem_req}, {31'h500, 1'b1});
    cyc(); mem_resp = 1; mem_rdata = 32'hCAFE; #1;
    chk("mid_new_rdata", a_ifu_rdata, 32'hCAFE);
    cyc(); clear_inputs();
    $display("txn: reset mid-store, then ifu fetch 0x500 complete");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
